// File: rtl/ea_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ea_sequencer_pkg : mode, ALU opcode and state encodings for the EA sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
package ea_sequencer_pkg;

  localparam logic [2:0] MODE_ZP    = 3'd0;
  localparam logic [2:0] MODE_ZP_X  = 3'd1;
  localparam logic [2:0] MODE_ZP_Y  = 3'd2;
  localparam logic [2:0] MODE_ABS   = 3'd3;
  localparam logic [2:0] MODE_ABS_X = 3'd4;
  localparam logic [2:0] MODE_ABS_Y = 3'd5;
  localparam logic [2:0] MODE_IND_X = 3'd6;
  localparam logic [2:0] MODE_IND_Y = 3'd7;

  // Shared with the arithmetic unit opcode decoder.
  localparam logic [1:0] ALU_ADR0 = 2'b00;
  localparam logic [1:0] ALU_ADR1 = 2'b01;
  localparam logic [1:0] ALU_ADC  = 2'b10;
  localparam logic [1:0] ALU_LD   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_LO   = 4'd1,
    ST_RD_HI   = 4'd2,
    ST_CAP_HI  = 4'd3,
    ST_CAP_LO  = 4'd4,
    ST_IDX_LO  = 4'd5,
    ST_IDX_HI  = 4'd6,
    ST_PTR_LO  = 4'd7,
    ST_PTR_HI  = 4'd8,
    ST_PTR_CAP = 4'd9,
    ST_DONE    = 4'd10
  } state_e;

  function automatic logic is_abs(input logic [2:0] m);
    return (m == MODE_ABS) || (m == MODE_ABS_X) || (m == MODE_ABS_Y);
  endfunction

  function automatic logic uses_x(input logic [2:0] m);
    return (m == MODE_ZP_X) || (m == MODE_ABS_X) || (m == MODE_IND_X);
  endfunction

  // Modes whose index add may carry into the high byte.
  function automatic logic full_add(input logic [2:0] m);
    return (m == MODE_ABS_X) || (m == MODE_ABS_Y) || (m == MODE_IND_Y);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ea_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ea_sequencer_if : control, memory and ALU signals of the EA sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface ea_sequencer_if;
  import ea_sequencer_pkg::*;

  logic        start;
  logic [2:0]  mode;
  logic [15:0] pc_in;
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic [7:0]  mem_rdata;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        pc_inc;
  logic        alu_req;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] ea;
  logic        ea_valid;
  logic        page_cross;
  logic        busy;

  modport master (
    input  start, mode, pc_in, x_reg, y_reg, mem_rdata, alu_out, alu_carry,
    output mem_addr, mem_rd, pc_inc, alu_req, alu_opcode, alu_a, alu_b,
           ea, ea_valid, page_cross, busy
  );

  modport slave (
    output start, mode, pc_in, x_reg, y_reg, mem_rdata, alu_out, alu_carry,
    input  mem_addr, mem_rd, pc_inc, alu_req, alu_opcode, alu_a, alu_b,
           ea, ea_valid, page_cross, busy
  );

endinterface
`default_nettype wire

// File: rtl/ea_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ea_sequencer : fetches operand bytes and forms 6502 effective addresses
// Revision 1.0
// ---------------------------------------------------------------------------
module ea_sequencer
  import ea_sequencer_pkg::*;
#(
  parameter logic [7:0] ZP_HI = 8'h00
) (
  input  wire logic       clk,
  input  wire logic       reset,
  ea_sequencer_if.master  bus
);

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  tmp_q, tmp_d;
  logic [15:0] ea_q, ea_d;
  logic        page_cross_q, page_cross_d;

  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        pc_inc;
  logic        alu_req;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        ea_valid;
  logic [7:0]  lo_inc;

  // Second pointer byte stays inside the pointer page.
  assign lo_inc = lo_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    tmp_d        = tmp_q;
    ea_d         = ea_q;
    page_cross_d = page_cross_q;
    mem_addr     = 16'h0000;
    mem_rd       = 1'b0;
    pc_inc       = 1'b0;
    alu_req      = 1'b0;
    alu_opcode   = ALU_ADR0;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    ea_valid     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d       = bus.mode;
          page_cross_d = 1'b0;
          state_d      = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        mem_addr = bus.pc_in;
        mem_rd   = 1'b1;
        pc_inc   = 1'b1;
        state_d  = is_abs(mode_q) ? ST_RD_HI : ST_CAP_LO;
      end
      ST_RD_HI: begin
        lo_d     = bus.mem_rdata;
        mem_addr = bus.pc_in;
        mem_rd   = 1'b1;
        pc_inc   = 1'b1;
        state_d  = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        hi_d    = bus.mem_rdata;
        state_d = (mode_q == MODE_ABS) ? ST_DONE : ST_IDX_LO;
      end
      ST_CAP_LO: begin
        lo_d = bus.mem_rdata;
        hi_d = ZP_HI;
        if (mode_q == MODE_ZP) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_IND_Y) begin
          state_d = ST_PTR_LO;
        end else begin
          state_d = ST_IDX_LO;
        end
      end
      ST_IDX_LO: begin
        alu_req    = 1'b1;
        alu_opcode = ALU_ADR0;
        alu_a      = lo_q;
        alu_b      = uses_x(mode_q) ? bus.x_reg : bus.y_reg;
        lo_d       = bus.alu_out;
        // IDX_HI must follow directly: the ALU holds this carry for one cycle only.
        if (full_add(mode_q)) begin
          page_cross_d = bus.alu_carry;
          state_d      = ST_IDX_HI;
        end else if (mode_q == MODE_IND_X) begin
          state_d = ST_PTR_LO;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_IDX_HI: begin
        alu_req    = 1'b1;
        alu_opcode = ALU_ADR1;
        alu_b      = hi_q;
        hi_d       = bus.alu_out;
        state_d    = ST_DONE;
      end
      ST_PTR_LO: begin
        mem_addr = {ZP_HI, lo_q};
        mem_rd   = 1'b1;
        state_d  = ST_PTR_HI;
      end
      ST_PTR_HI: begin
        tmp_d    = bus.mem_rdata;
        mem_addr = {ZP_HI, lo_inc};
        mem_rd   = 1'b1;
        state_d  = ST_PTR_CAP;
      end
      ST_PTR_CAP: begin
        hi_d    = bus.mem_rdata;
        lo_d    = tmp_q;
        state_d = (mode_q == MODE_IND_Y) ? ST_IDX_LO : ST_DONE;
      end
      ST_DONE: begin
        ea_d     = {hi_q, lo_q};
        ea_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= 3'd0;
      lo_q         <= 8'h00;
      hi_q         <= 8'h00;
      tmp_q        <= 8'h00;
      ea_q         <= 16'h0000;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      tmp_q        <= tmp_d;
      ea_q         <= ea_d;
      page_cross_q <= page_cross_d;
    end
  end

  assign bus.mem_addr   = mem_addr;
  assign bus.mem_rd     = mem_rd;
  assign bus.pc_inc     = pc_inc;
  assign bus.alu_req    = alu_req;
  assign bus.alu_opcode = alu_opcode;
  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  // The final address is shown in DONE itself, alongside the valid pulse.
  assign bus.ea         = (state_q == ST_DONE) ? {hi_q, lo_q} : ea_q;
  assign bus.ea_valid   = ea_valid;
  assign bus.page_cross = page_cross_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ea_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ea_sequencer : scoreboard bench with memory, PC and ALU models
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ea_sequencer;
  import ea_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ea_sequencer_if bus ();

  ea_sequencer #(.ZP_HI(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] ea;
    logic        pcx;
    int          lat;
    int          npc;
    logic        chk_ptr;
    logic [15:0] ra;
    logic [15:0] rb;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] rd_hist[$];
  logic [7:0]  mem [0:65535];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          pcinc_cnt = 0;
  int          nvalid = 0;

  // Program counter model
  logic [15:0] pc = 16'h0000;
  logic [15:0] pc_val = 16'h0000;
  logic        pc_load = 1'b0;
  always @(posedge clk) begin
    if (pc_load) pc <= pc_val;
    else if (bus.pc_inc) pc <= pc + 16'd1;
  end
  assign bus.pc_in = pc;

  // Memory model: data valid the cycle after the read strobe
  logic [7:0] rdata = 8'h00;
  always @(posedge clk) if (bus.mem_rd) rdata <= mem[bus.mem_addr];
  assign bus.mem_rdata = rdata;

  // ALU model: ADR0 = a + b, ADR1 = a + b + carry held from the previous op
  logic       alu_cq = 1'b0;
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    if (bus.alu_opcode == ALU_ADR1) alu_sum = alu_sum + {8'd0, alu_cq};
  end
  assign bus.alu_out   = alu_sum[7:0];
  assign bus.alu_carry = alu_sum[8];
  always @(posedge clk) if (bus.alu_req) alu_cq <= alu_sum[8];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.pc_inc) pcinc_cnt++;
      if (bus.mem_rd) rd_hist.push_back(bus.mem_addr);
      if (bus.ea_valid) begin
        nvalid++;
        if (sb.size() == 0) begin
          check_val("unexpected_ea_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("ea", {16'd0, bus.ea}, {16'd0, e.ea});
          check_val("page_cross", {31'd0, bus.page_cross}, {31'd0, e.pcx});
          check_val("latency", cyc - acc_cyc, e.lat);
          check_val("pc_inc_count", pcinc_cnt, e.npc);
          if (e.chk_ptr) begin
            if (rd_hist.size() < 2) begin
              check_val("ptr_read_count", rd_hist.size(), 2);
            end else begin
              check_val("ptr_rd_a", {16'd0, rd_hist[rd_hist.size()-2]}, {16'd0, e.ra});
              check_val("ptr_rd_b", {16'd0, rd_hist[rd_hist.size()-1]}, {16'd0, e.rb});
            end
          end
        end
      end
      if (bus.start && !bus.busy) begin
        acc_cyc   = cyc;
        pcinc_cnt = 0;
        rd_hist.delete();
      end
    end
  end

  // Launch one sequence; with hold set, start stays high and mode is scrambled while busy.
  task automatic run_seq(input logic [2:0] m, input logic [15:0] pc0,
                         input logic [7:0] xv, input logic [7:0] yv,
                         input logic [15:0] e_ea, input logic e_pcx,
                         input int e_lat, input int e_npc,
                         input logic e_ptr, input logic [15:0] e_ra,
                         input logic [15:0] e_rb, input logic hold);
    exp_t x;
    int   nv0;
    bit   done;
    x.ea = e_ea; x.pcx = e_pcx; x.lat = e_lat; x.npc = e_npc;
    x.chk_ptr = e_ptr; x.ra = e_ra; x.rb = e_rb;
    @(posedge clk); #1;
    nv0       = nvalid;
    bus.mode  = m;
    bus.x_reg = xv;
    bus.y_reg = yv;
    pc_val    = pc0;
    pc_load   = 1'b1;
    bus.start = 1'b1;
    sb.push_back(x);
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #1;
      pc_load = 1'b0;
      if (nvalid != nv0) begin
        done      = 1'b1;
        bus.start = 1'b0;
      end else if (hold) begin
        bus.mode = 3'($urandom_range(0, 7));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!done) begin
      check_val("timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12;
    mem[16'h0300] = 8'h80;
    mem[16'h0400] = 8'h20; mem[16'h0024] = 8'h74; mem[16'h0025] = 8'h20;
    mem[16'h0500] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0600] = 8'h42;
    mem[16'h0700] = 8'h34; mem[16'h0701] = 8'h12;
    mem[16'h0800] = 8'hF0;
    mem[16'h0900] = 8'h10; mem[16'h0901] = 8'h40;
    mem[16'h0A00] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h33;
    mem[16'h0B00] = 8'hFF;
    mem[16'h0C00] = 8'h00; mem[16'h0C01] = 8'hC0;
    mem[16'h0D00] = 8'hFF; mem[16'h0D01] = 8'h20;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 3'd0;
    bus.x_reg = 8'h00;
    bus.y_reg = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_ea", {16'd0, bus.ea}, 32'd0);
    check_val("rst_page_cross", {31'd0, bus.page_cross}, 32'd0);
    check_val("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check_val("rst_ea_valid", {31'd0, bus.ea_valid}, 32'd0);

    //       mode        pc        x      y      ea        pcx  lat npc ptr ra        rb        hold
    run_seq(MODE_ABS_X, 16'h0200, 8'h20, 8'h05, 16'h1310, 1'b1, 6, 2, 1'b0, 16'h0, 16'h0, 1'b0);
    run_seq(MODE_ZP_X,  16'h0300, 8'h90, 8'h01, 16'h0010, 1'b0, 4, 1, 1'b0, 16'h0, 16'h0, 1'b0);
    run_seq(MODE_IND_X, 16'h0400, 8'h04, 8'h77, 16'h2074, 1'b0, 7, 1, 1'b1, 16'h0024, 16'h0025, 1'b0);
    run_seq(MODE_IND_Y, 16'h0500, 8'h55, 8'h10, 16'h1244, 1'b0, 8, 1, 1'b1, 16'h00FF, 16'h0000, 1'b0);
    run_seq(MODE_ZP,    16'h0600, 8'h11, 8'h22, 16'h0042, 1'b0, 3, 1, 1'b0, 16'h0, 16'h0, 1'b0);
    run_seq(MODE_ABS,   16'h0700, 8'h11, 8'h22, 16'h1234, 1'b0, 4, 2, 1'b0, 16'h0, 16'h0, 1'b0);
    run_seq(MODE_ZP_Y,  16'h0800, 8'h01, 8'h20, 16'h0010, 1'b0, 4, 1, 1'b0, 16'h0, 16'h0, 1'b0);
    run_seq(MODE_ABS_Y, 16'h0900, 8'hF0, 8'h05, 16'h4015, 1'b0, 6, 2, 1'b0, 16'h0, 16'h0, 1'b0);
    run_seq(MODE_IND_Y, 16'h0A00, 8'h00, 8'h20, 16'h3410, 1'b1, 8, 1, 1'b1, 16'h0040, 16'h0041, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_val("ea_held", {16'd0, bus.ea}, 32'h3410);
    check_val("pcx_held", {31'd0, bus.page_cross}, 32'd1);

    // Abort an IND_Y sequence in PTR_HI
    bus.mode  = MODE_IND_Y;
    bus.y_reg = 8'h10;
    pc_val    = 16'h0B00;
    pc_load   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    pc_load   = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_ptr_hi_addr", {16'd0, bus.mem_addr}, 32'h0000);
    check_val("abort_ptr_hi_rd", {31'd0, bus.mem_rd}, 32'd1);
    begin
      int nv_before;
      nv_before = nvalid;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
      check_val("abort_outs", {bus.mem_addr, 8'd0, bus.mem_rd, bus.pc_inc, bus.alu_req,
                               bus.alu_opcode, bus.ea_valid, bus.page_cross, 1'b0},
                32'd0);
      check_val("abort_alu_ab", {16'd0, bus.alu_a, bus.alu_b}, 32'd0);
      check_val("abort_ea", {16'd0, bus.ea}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      check_val("abort_no_valid", nvalid, nv_before);
    end

    run_seq(MODE_ABS,   16'h0C00, 8'h00, 8'h00, 16'hC000, 1'b0, 4, 2, 1'b0, 16'h0, 16'h0, 1'b0);

    begin
      int nv_before;
      nv_before = nvalid;
      run_seq(MODE_ABS_Y, 16'h0D00, 8'h02, 8'h01, 16'h2100, 1'b1, 6, 2, 1'b0, 16'h0, 16'h0, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check_val("hold_start_one_valid", nvalid, nv_before + 1);
      check_val("hold_start_idle", {31'd0, bus.busy}, 32'd0);
    end

    check_val("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
